uart_tx: RTL and testbench

Asynchronous UART transmitter: the transmit side of the team's 8N1-style serial link, sitting between on-chip logic producing bytes and the FPGA TX pin. It accepts bytes through a valid/ready handshake into a one-entry holding register and serialises them LSB first with start, optional parity and 1 or 2 stop bits. It sustains back-to-back frames with zero idle gap.

---
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a one-entry holding register,
// serialised LSB first with start, optional parity and 1 or 2 stop bits.
module uart_tx #(
  parameter int clk_freq  = 12000000,
  parameter int baud      = 115200,
  parameter int parity    = 0,
  parameter int stop_bits = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = (clk_freq + baud / 2) / baud;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic PAR_EN   = (parity != 0);
  localparam logic PAR_ODD  = (parity == 1);
  localparam logic TWO_STOP = (stop_bits == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;
  logic [7:0]    hold_data;
  logic          hold_valid;
  logic          par_bit;
  logic          bit_end;
  logic          last_stop;
  logic          load;

  assign bit_end   = (cnt == LAST);
  assign last_stop = ~TWO_STOP | stop_idx;
  // Load from IDLE, or on the final stop edge so the next start bit follows with no gap.
  assign load      = hold_valid & ((state == IDLE) | ((state == STOP) & bit_end & last_stop));
  assign tx_ready  = ~hold_valid;
  assign tx_busy   = (state != IDLE) | hold_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_data;
      end
      if (bit_end) cnt <= '0;
      else         cnt <= cnt + CW'(1);

      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= shift[0];
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (PAR_EN) begin
              state <= PARITY;
              tx    <= par_bit;
            end else begin
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= {1'b0, shift[7:1]};
            tx      <= shift[1];
          end
        end
        PARITY: if (bit_end) begin
          state    <= STOP;
          tx       <= 1'b1;
          stop_idx <= 1'b0;
        end
        STOP: if (bit_end) begin
          if (last_stop) begin
            tx_done <= 1'b1;
            state   <= IDLE;
            tx      <= 1'b1;
          end else begin
            stop_idx <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase

      // Parity comes from the byte as loaded, since the shifter is consumed during DATA.
      if (load) begin
        shift      <= hold_data;
        par_bit    <= ^hold_data ^ PAR_ODD;
        hold_valid <= 1'b0;
        state      <= START;
        tx         <= 1'b0;
        cnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O1 at DIV=10) driven in parallel,
// checked every cycle against a frame-level model plus literal expectations.
module tb_uart_tx;
  localparam int DIV = 10;
  localparam int N   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic [N-1:0] tx_w, ready_w, busy_w, done_w;
  logic         cmp_en = 1'b0;

  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction
  function automatic int stp_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int nbits(input int i);
    return 10 + ((par_of(i) != 0) ? 1 : 0) + stp_of(i) - 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gd
    uart_tx #(
      .clk_freq (1000000),
      .baud     (100000),
      .parity   ((g == 1) ? 2 : (g == 2) ? 1 : 0),
      .stop_bits((g == 1) ? 2 : 1)
    ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .tx_data (tx_data),
      .tx_start(tx_start),
      .tx_ready(ready_w[g]),
      .tx      (tx_w[g]),
      .tx_busy (busy_w[g]),
      .tx_done (done_w[g])
    );
  end

  // Frame-level model: a frame is a bit vector; tx is bit[pos/DIV] while a frame is active.
  function automatic logic [11:0] build(input logic [7:0] b, input int p);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (p == 2) f[9] = ^b;
    else if (p == 1) f[9] = ~^b;
    return f;
  endfunction

  logic        m_hv  [N];
  logic [7:0]  m_hb  [N];
  logic        m_act [N];
  int          m_pos [N];
  logic [11:0] m_fr  [N];
  logic        m_done[N];
  logic [7:0]  sent0[$];

  always @(posedge clk or negedge resetn) begin
    logic ld, acc;
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        m_hv[i] = 1'b0; m_act[i] = 1'b0; m_pos[i] = 0; m_done[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_done[i] = 1'b0;
        if (m_act[i]) begin
          if (m_pos[i] == nbits(i) * DIV - 1) begin
            m_act[i] = 1'b0; m_done[i] = 1'b1;
          end else m_pos[i] = m_pos[i] + 1;
        end
        ld  = m_hv[i] && !m_act[i];
        acc = tx_start && !m_hv[i];
        if (ld) begin
          m_fr[i] = build(m_hb[i], par_of(i));
          m_act[i] = 1'b1; m_pos[i] = 0; m_hv[i] = 1'b0;
          if (i == 0) sent0.push_back(m_hb[i]);
        end
        if (acc) begin
          m_hv[i] = 1'b1; m_hb[i] = tx_data;
        end
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int idx, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, idx, $time, a, e);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < N; i++) begin
          chk("tx",       i, int'(tx_w[i]),    int'(m_act[i] ? m_fr[i][m_pos[i] / DIV] : 1'b1));
          chk("tx_ready", i, int'(ready_w[i]), int'(!m_hv[i]));
          chk("tx_busy",  i, int'(busy_w[i]),  int'(m_act[i] || m_hv[i]));
          chk("tx_done",  i, int'(done_w[i]),  int'(m_done[i]));
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [11:0] samp[N];
  int          done_at[N];

  // Accept one byte from idle, then sample each line mid-bit and note when tx_done rises.
  task automatic frame_probe(input logic [7:0] b);
    tx_data = b; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    for (int i = 0; i < N; i++) begin samp[i] = '1; done_at[i] = -1; end
    for (int c = 0; c < 130; c++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (c % DIV == 5 && c / DIV < 12) samp[i][c / DIV] = tx_w[i];
        if (done_w[i] && done_at[i] < 0) done_at[i] = c;
      end
    end
    tick(1);
  endtask

  initial begin
    int edges, nd, d1, d2, sz;
    logic [N-1:0] prev;
    resetn = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    fork cmp_loop(); join_none
    tick(5);
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Reset state and a quiet line
    @(negedge clk);
    chk("rst_tx", 0, int'(tx_w[0]), 1);
    chk("rst_ready", 0, int'(ready_w[0]), 1);
    chk("rst_busy", 0, int'(busy_w[0]), 0);
    edges = 0; prev = tx_w;
    repeat (2000) begin
      @(negedge clk);
      if (tx_w != prev) edges++;
      prev = tx_w;
    end
    chk("idle_edges", 0, edges, 0);
    tick(1);

    // 0x55 on 8N1: 0,1,0,1,0,1,0,1,0,1 and tx_done 100 cycles after start
    frame_probe(8'h55);
    chk("frame55", 0, int'(samp[0][9:0]), int'(10'b1010101010));
    chk("done55", 0, done_at[0], 100);

    // 0x07: even parity bit 1 with 2 stops (120 cycles), odd parity bit 0 (110 cycles)
    frame_probe(8'h07);
    chk("par_even", 1, int'(samp[1][9]), 1);
    chk("len_8E2", 1, done_at[1], 120);
    chk("par_odd", 2, int'(samp[2][9]), 0);
    chk("len_8O1", 2, done_at[2], 110);
    chk("len_8N1", 0, done_at[0], 100);
    tick(20);

    // Back-to-back with tx_start held
    tx_data = 8'hA3; tx_start = 1'b1;
    tick(1);
    tx_data = 8'h0F;
    @(negedge clk);
    chk("b2b_ready_held", 0, int'(ready_w[0]), 0);
    tick(1);
    @(negedge clk);
    chk("b2b_ready_loaded", 0, int'(ready_w[0]), 1);
    tick(1);
    tx_start = 1'b0;
    @(negedge clk);
    chk("b2b_ready_second", 0, int'(ready_w[0]), 0);
    nd = 0; d1 = 0; d2 = 0;
    for (int c = 0; c < 350; c++) begin
      @(negedge clk);
      if (done_w[0]) begin
        if (nd == 0) d1 = c;
        else if (nd == 1) d2 = c;
        nd++;
      end
    end
    chk("b2b_done_count", 0, nd, 2);
    chk("b2b_spacing", 0, d2 - d1, 100);
    chk("b2b_bytes", 0, int'({sent0[sent0.size()-2], sent0[sent0.size()-1]}), int'(16'hA30F));
    tick(1);

    // Overwrite guard: 0x22 offered while the holding register is full
    sz = sent0.size();
    tx_data = 8'h11; tx_start = 1'b1;
    tick(1);
    tx_data = 8'h33;
    tick(2);
    tx_start = 1'b0;
    tick(10);
    tx_data = 8'h22; tx_start = 1'b1;
    @(negedge clk);
    chk("guard_ready", 0, int'(ready_w[0]), 0);
    tick(20);
    tx_start = 1'b0; tx_data = 8'h00;
    tick(300);
    chk("guard_count", 0, sent0.size() - sz, 2);
    chk("guard_bytes", 0, int'({sent0[sz], sent0[sz+1]}), int'(16'h1133));

    // Reset during DATA bit 4
    tx_data = 8'hF0; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(55);
    chk("pre_rst_busy", 0, int'(busy_w[0]), 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_tx", 0, int'(tx_w[0]), 1);
    chk("rst_mid_busy", 0, int'(busy_w[0]), 0);
    chk("rst_mid_done", 0, int'(done_w[0]), 0);
    tick(3);
    resetn = 1'b1;
    nd = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("rst_no_done", 0, nd, 0);
    tick(1);
    tx_data = 8'h5A; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    nd = 0;
    repeat (130) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("post_rst_done", 0, nd, 1);
    chk("post_rst_byte", 0, int'(sent0[sent0.size()-1]), int'(8'h5A));
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
